uart_rx_deserializer: RTL

//  Receive-side counterpart of the UART transmission stage: samples serial RxD with a 16x oversampling strobe and

---
 rtl/uart_rx_deserializer_pkg.sv | 28 ++
 rtl/uart_sync2.sv | 27 ++
 rtl/uart_rx_deserializer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deserializer_pkg.sv
// Shared constants, state encodings and helpers for the UART receive path.
package uart_rx_deserializer_pkg;

    // Payload width of one UART character.
    localparam int DATA_BITS = 8;

    // Receiver FSM state encodings (3-bit, kept stable for legacy tooling).
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Everything delivered downstream when a frame completes.
    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 perror;
        logic                 ferror;
    } rx_result_t;

    // High when data plus received parity bit violate the selected parity sense.
    function automatic logic parity_fail(input logic [DATA_BITS-1:0] data,
                                         input logic                 par,
                                         input logic                 odd);
        return ((^{data, par}) != odd);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage shift; reset value chosen so the synchronised line looks idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: oversampled start detection, LSB-first 8N/parity/stop
// deserialisation, registered byte/error outputs with a one-clock valid pulse.
module uart_rx_deserializer
    import uart_rx_deserializer_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RxD,
    input  logic                 Rx_sample_ENABLE,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR,
    output logic                 Rx_BUSY
);

    localparam int                SCNT_W    = $clog2(OVERSAMPLE);
    localparam logic [SCNT_W-1:0] SCNT_ZERO = {SCNT_W{1'b0}};
    localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);
    localparam logic [SCNT_W-1:0] SCNT_HALF = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]        BIT_ZERO  = 3'd0;
    localparam logic [2:0]        BIT_ONE   = 3'd1;
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    logic                 rxd_s;
    logic                 bit_end_s;

    logic [2:0]           state_r,  state_nxt_s;
    logic [SCNT_W-1:0]    scnt_r,   scnt_nxt_s;
    logic [2:0]           bitcnt_r, bitcnt_nxt_s;
    logic                 busy_r,   busy_nxt_s;
    logic [DATA_BITS-1:0] shreg_r,  shreg_nxt_s;
    logic                 par_r,    par_nxt_s;
    rx_result_t           result_r, result_nxt_s;
    logic                 valid_r,  valid_nxt_s;

    // Line idles high, so the synchroniser comes out of reset at 1.
    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_rxd_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (RxD),
        .q     (rxd_s)
    );

    // Last strobe of a bit period: the counter wraps to zero here.
    assign bit_end_s = (scnt_r == SCNT_LAST);

    // Next-state logic; everything except the valid pulse only moves on strobes.
    always_comb begin
        state_nxt_s  = state_r;
        scnt_nxt_s   = scnt_r;
        bitcnt_nxt_s = bitcnt_r;
        busy_nxt_s   = busy_r;
        shreg_nxt_s  = shreg_r;
        par_nxt_s    = par_r;
        result_nxt_s = result_r;
        valid_nxt_s  = 1'b0;

        if (Rx_sample_ENABLE) begin
            case (state_r)
                ST_IDLE: begin
                    // Level-triggered: a held-low line (break) restarts frames.
                    if (!rxd_s) begin
                        state_nxt_s = ST_START;
                        scnt_nxt_s  = SCNT_ONE;
                    end else begin
                        scnt_nxt_s  = SCNT_ZERO;
                    end
                end
                ST_START: begin
                    if (scnt_r == SCNT_HALF) begin
                        // Mid start bit: re-sample to reject glitches. Counter
                        // restarts so later samples land mid-bit too.
                        scnt_nxt_s = SCNT_ZERO;
                        if (!rxd_s) begin
                            state_nxt_s  = ST_DATA;
                            busy_nxt_s   = 1'b1;
                            bitcnt_nxt_s = BIT_ZERO;
                        end else begin
                            state_nxt_s  = ST_IDLE;
                        end
                    end else begin
                        scnt_nxt_s = scnt_r + SCNT_ONE;
                    end
                end
                ST_DATA: begin
                    scnt_nxt_s = scnt_r + SCNT_ONE;
                    if (bit_end_s) begin
                        // LSB arrives first, so shift in from the top.
                        shreg_nxt_s = {rxd_s, shreg_r[DATA_BITS-1:1]};
                        if (bitcnt_r == BIT_LAST) begin
                            state_nxt_s  = ST_PARITY;
                            bitcnt_nxt_s = BIT_ZERO;
                        end else begin
                            bitcnt_nxt_s = bitcnt_r + BIT_ONE;
                        end
                    end else begin
                        shreg_nxt_s = shreg_r;
                    end
                end
                ST_PARITY: begin
                    scnt_nxt_s = scnt_r + SCNT_ONE;
                    if (bit_end_s) begin
                        par_nxt_s   = rxd_s;
                        state_nxt_s = ST_STOP;
                    end else begin
                        par_nxt_s   = par_r;
                    end
                end
                ST_STOP: begin
                    scnt_nxt_s = scnt_r + SCNT_ONE;
                    if (bit_end_s) begin
                        // Errors still deliver the byte; they are flagged, not dropped.
                        result_nxt_s.data   = shreg_r;
                        result_nxt_s.perror = parity_fail(shreg_r, par_r, PARITY_ODD);
                        result_nxt_s.ferror = ~rxd_s;
                        valid_nxt_s         = 1'b1;
                        busy_nxt_s          = 1'b0;
                        // Leaving mid stop bit lets a back-to-back start edge be caught.
                        state_nxt_s         = ST_IDLE;
                    end else begin
                        result_nxt_s = result_r;
                    end
                end
                default: begin
                    state_nxt_s  = ST_IDLE;
                    scnt_nxt_s   = SCNT_ZERO;
                    bitcnt_nxt_s = BIT_ZERO;
                    busy_nxt_s   = 1'b0;
                end
            endcase
        end else begin
            // No strobe: FSM frozen, outputs hold.
            state_nxt_s = state_r;
        end
    end

    // Control state: FSM, oversample counter, bit counter, busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            scnt_r   <= SCNT_ZERO;
            bitcnt_r <= BIT_ZERO;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            scnt_r   <= scnt_nxt_s;
            bitcnt_r <= bitcnt_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    // Datapath: shift register and captured parity bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_r <= {DATA_BITS{1'b0}};
            par_r   <= 1'b0;
        end else begin
            shreg_r <= shreg_nxt_s;
            par_r   <= par_nxt_s;
        end
    end

    // Delivered result and its one-clock valid pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_r <= '{data: {DATA_BITS{1'b0}}, perror: 1'b0, ferror: 1'b0};
            valid_r  <= 1'b0;
        end else begin
            result_r <= result_nxt_s;
            valid_r  <= valid_nxt_s;
        end
    end

    assign Rx_DATA   = result_r.data;
    assign Rx_PERROR = result_r.perror;
    assign Rx_FERROR = result_r.ferror;
    assign Rx_VALID  = valid_r;
    assign Rx_BUSY   = busy_r;

endmodule
